seq_12demux: RTL
================

SEQ_12DEMUX -- requirements
Module: seq_12demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of input and both output ports.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  input data.
- d_valid  input  1  input offer.
- d_ready  output  1  input accepted when d_valid and d_ready both high.
- sel  input  1  destination in sel mode: 0 = a, 1 = b; sampled with d.
- mode  input  1  0 = sel-directed, 1 = alternating.
- a  output  WIDTH  port-a data.
- a_valid  output  1  port-a offer.
- a_ready  input  1  port-a sink ready.
- b  output  WIDTH  port-b data.
- b_valid  output  1  port-b offer.
- b_ready  input  1  port-b sink ready.

Function
REQ-003 SHALL route each accepted input word to exactly one output port; no duplication, no loss.
REQ-004 Destination SHALL be sel when mode=0, and the internal toggle register tgl (0 = a, 1 = b) when mode=1.
REQ-005 tgl SHALL invert on every accepted transfer while mode=1 and hold otherwise.
REQ-006 Each port SHALL own a one-entry output slot: data register plus full flag; x_valid equals the full flag.
REQ-007 A slot SHALL drain on x_valid and x_ready both high.
REQ-008 d_ready SHALL be high iff the destination slot is empty or draining in the same cycle; combinational path from sel/mode/x_ready to d_ready is permitted.
REQ-009 Latency SHALL be 1 cycle: a word accepted at edge N is visible with x_valid high after edge N.
REQ-010 Fill and drain of the same slot in one cycle SHALL keep full=1 and load the new word, sustaining 1 word per cycle per port.
REQ-011 x and x_valid SHALL stay stable while x_valid is high and x_ready is low.
REQ-012 The non-destination slot SHALL drain independently of input activity; the two ports never block each other.
REQ-013 With d_valid low, no slot fill and no tgl change SHALL occur.
REQ-014 A mode change SHALL take effect on the same cycle; tgl is not reset by a mode change.
REQ-015 x data registers SHALL load only on accepted transfers; no other writes.

Reset
REQ-016 rst high SHALL force, immediately and without waiting for clk:
- a_valid = 0, b_valid = 0;
- a = 0, b = 0;
- tgl = 0.
REQ-017 Slot contents held at reset assertion SHALL be discarded.
REQ-018 While rst is high, d_ready SHALL be 0 and no transfer is accepted.
REQ-019 The first edge after rst deasserts SHALL be able to accept a transfer.

Structure
REQ-020 Shared package SHALL hold:
- constants PORT_A=0, PORT_B=1;
- constants MODE_SEL=0, MODE_ALT=1;
- default width constant 8.
REQ-021 The output slot SHALL be a sub-module, demux_slot (WIDTH parameter; load, data in, ready in; data out, valid out), instantiated twice.
REQ-022 Routing and tgl logic SHALL reside in seq_12demux.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset: rst pulse mid-stream with a_valid=1 -> a_valid=0, a=0 asynchronously; d_ready=0 during rst.
- Sel mode streaming: mode=0, a_ready=b_ready=1, d=0x11,0x22,0x33 with sel=0,1,0 on consecutive cycles -> a shows 0x11 then 0x33, b shows 0x22, each 1 cycle after accept, no bubbles.
- Alternating mode: mode=1 after reset, d=0xA0..0xA3 -> 0xA0, 0xA2 on a; 0xA1, 0xA3 on b.
- Backpressure: a_ready=0, sel=0 -> 0x55 held on a; second sel=0 word sees d_ready=0; sel=1 word 0x66 still passes to b.
- Simultaneous fill and drain: a full with 0x01, a_ready=1, new sel=0 word 0x02 same cycle -> a_valid stays 1, a=0x02 next cycle.
- Mode switch: mode=1 toggles twice, then mode=0 for 2 words, then mode=1 -> alternation resumes from held tgl.

Source files
------------

// File: rtl/seq_12demux_pkg.sv
// Shared constants for the two-way sequential demultiplexer.
package seq_12demux_pkg;
    localparam logic [0:0] PORT_A   = 1'b0;
    localparam logic [0:0] PORT_B   = 1'b1;
    localparam logic [0:0] MODE_SEL = 1'b0;
    localparam logic [0:0] MODE_ALT = 1'b1;
    localparam int         DEFAULT_WIDTH = 8;
endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: data register plus full flag, refilled while draining.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    logic [WIDTH-1:0] data_reg;
    logic             full_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            // A load wins over a drain so back-to-back words keep the slot full.
            data_reg <= din;
            full_reg <= 1'b1;
        end else if (full_reg && ready) begin
            full_reg <= 1'b0;
        end
    end

    assign dout  = data_reg;
    assign valid = full_reg;
endmodule

// File: rtl/seq_12demux.sv
// Routes each accepted input word to port a or b, by sel or by an alternating toggle.
module seq_12demux
    import seq_12demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             sel,
    input  logic             mode,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    input  logic             b_ready
);
    logic             tgl_reg;
    logic             dest;
    logic             accept;
    logic [1:0]       slot_load;
    logic [1:0]       slot_valid;
    logic [1:0]       sink_ready;
    logic [1:0]       slot_free;
    logic [WIDTH-1:0] slot_data [2];

    assign sink_ready = {b_ready, a_ready};
    assign dest       = (mode == MODE_ALT) ? tgl_reg : sel;
    // A slot can take a word if it is empty or its sink takes the current word this cycle.
    assign slot_free  = ~slot_valid | sink_ready;
    assign d_ready    = ~rst & slot_free[dest];
    assign accept     = d_valid & d_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgl_reg <= 1'b0;
        end else if (accept && (mode == MODE_ALT)) begin
            tgl_reg <= ~tgl_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_load[gi] = accept & (dest == 1'(gi));
            demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (slot_load[gi]),
                .din   (d),
                .ready (sink_ready[gi]),
                .dout  (slot_data[gi]),
                .valid (slot_valid[gi])
            );
        end
    endgenerate

    assign a       = slot_data[PORT_A];
    assign a_valid = slot_valid[PORT_A];
    assign b       = slot_data[PORT_B];
    assign b_valid = slot_valid[PORT_B];
endmodule
